// File: rtl/aes_sbox_word_sub.sv
// Multi-cycle AES SubBytes/InvSubBytes engine: LANES S-box lookups per beat over one word.
// Optional inverse tables are built only when AES_SBOX_INV_EN is defined.
module aes_sbox_word_sub #(
    parameter int WORD_BYTES = 16,
    parameter int LANES      = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    abort,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*WORD_BYTES-1:0] in_data,
    input  logic                    in_inv,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*WORD_BYTES-1:0] out_data,
    output logic                    busy
);

    localparam int BEATS = WORD_BYTES / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_reg;
    logic [BW-1:0]             beat_reg;
    logic [8*WORD_BYTES-1:0]   work_reg;
    logic                      inv_reg;
    logic                      out_valid_reg;
    logic                      accept;
    logic [7:0]                sub_byte [LANES];

    // Each row holds 16 table entries, entry 0 in the most significant byte.
    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [127:0] row;
        row = '0;
        case (x[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
            default: row = '0;
        endcase
        return row[8*(15 - int'(x[3:0])) +: 8];
    endfunction

`ifdef AES_SBOX_INV_EN
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [127:0] row;
        row = '0;
        case (x[7:4])
            4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
            4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
            4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
            4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
            4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
            4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
            4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
            4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
            4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
            4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
            4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
            4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
            4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
            4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
            4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
            4'hf: row = 128'h172b047eba77d626e169146355210c7d;
            default: row = '0;
        endcase
        return row[8*(15 - int'(x[3:0])) +: 8];
    endfunction
`endif

    assign in_ready  = !abort && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_reg;
    assign out_data  = work_reg;
    assign busy      = (state_reg != IDLE);

    // One lookup per lane on the bytes selected by the current beat.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0] cur_byte;
        assign cur_byte = work_reg[8*(int'(beat_reg)*LANES + gi) +: 8];
`ifdef AES_SBOX_INV_EN
        assign sub_byte[gi] = inv_reg ? inv_sbox(cur_byte) : fwd_sbox(cur_byte);
`else
        assign sub_byte[gi] = fwd_sbox(cur_byte);
`endif
    end

`ifndef AES_SBOX_INV_EN
    logic unused_inv;
    assign unused_inv = ^{in_inv, inv_reg};
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= IDLE;
            beat_reg      <= '0;
            work_reg      <= '0;
            inv_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else if (abort) begin
            // Flush control only; data registers keep their contents.
            state_reg     <= IDLE;
            beat_reg      <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        work_reg  <= in_data;
`ifdef AES_SBOX_INV_EN
                        inv_reg   <= in_inv;
`else
                        inv_reg   <= 1'b0;
`endif
                        beat_reg  <= '0;
                        state_reg <= SUB;
                    end
                end
                SUB: begin
                    for (int l = 0; l < LANES; l++) begin
                        work_reg[8*(int'(beat_reg)*LANES + l) +: 8] <= sub_byte[l];
                    end
                    if (beat_reg == BW'(BEATS - 1)) begin
                        beat_reg      <= '0;
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end else begin
                        beat_reg <= beat_reg + BW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (accept) begin
                            work_reg  <= in_data;
`ifdef AES_SBOX_INV_EN
                            inv_reg   <= in_inv;
`else
                            inv_reg   <= 1'b0;
`endif
                            beat_reg  <= '0;
                            state_reg <= SUB;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    beat_reg      <= '0;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
